storage_arbiter: RTL and testbench

- Parametrised N-channel arbiter between matrix-storage clients (input, display, calculator, future DMA/UART-load) and the single-port Matrix_storage.
- Replaces the combinational enable-priority storage mux.
- Adds round-robin or fixed-priority arbitration, per-channel grant/read-valid handshakes, burst locking with a starvation guard, and read-latency tracking with channel tags.

---
 rtl/storage_arbiter_pkg.sv | 20 ++
 rtl/storage_arbiter_picker.sv | 33 +++
 rtl/storage_arbiter.sv | 136 +++++++++++++
 tb/tb_storage_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/storage_arbiter_pkg.sv
// Shared definitions for the matrix-storage arbiter and its clients.
package storage_arbiter_pkg;

    // Storage geometry defaults, kept in step with Matrix_storage.
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 32;

    // Arbitration mode encodings.
    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    // Index width for n items; never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        for (w = 1; (32'd1 << w) < n; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/storage_arbiter_picker.sv
// Rotating priority picker: first requester at or after the start index, wrapping.
module rr_priority_picker
    import storage_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned IDX_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_start,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    logic [IDX_W-1:0] w_cand;

    // Scan channels from the start index upward and keep the first requester.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_cand = IDX_W'((32'(i_start) + i) % NUM_CH);
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/storage_arbiter.sv
// N-channel arbiter in front of the single-port matrix storage, with burst locking,
// a starvation guard and tagged read-latency tracking.
module storage_arbiter
    import storage_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned ARB_MODE = ARB_RR,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        i_req,
    input  logic [NUM_CH-1:0]        i_we,
    input  logic [NUM_CH-1:0]        i_lock,
    input  logic [NUM_CH*ADDR_W-1:0] i_addr,
    input  logic [NUM_CH*DATA_W-1:0] i_wdata,
    output logic [NUM_CH-1:0]        o_gnt,
    output logic [NUM_CH-1:0]        o_rvalid,
    output logic [DATA_W-1:0]        o_rdata,
    output logic [ADDR_W-1:0]        o_storage_addr,
    output logic [DATA_W-1:0]        o_storage_data,
    output logic                     o_storage_we,
    input  logic [DATA_W-1:0]        i_storage_rdata,
    output logic                     o_busy
);

    localparam int unsigned IDX_W = clog2(NUM_CH);
    localparam int unsigned CNT_W = clog2(LOCK_MAX + 1);

    logic [IDX_W-1:0]  r_ptr;
    logic              r_lock_vld;
    logic [IDX_W-1:0]  r_lock_ch;
    logic [CNT_W-1:0]  r_lock_cnt;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [IDX_W-1:0]  r_pipe_id [RD_LAT];

    logic [IDX_W-1:0]  w_start;
    logic [NUM_CH-1:0] w_pick_gnt;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic              w_cont;
    logic [IDX_W-1:0]  w_idx;
    logic              w_any;

    // Fixed priority is the rotating picker pinned to start at channel 0.
    assign w_start = (ARB_MODE == ARB_FIXED) ? '0 : r_ptr;

    rr_priority_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .i_req   (i_req),
        .i_start (w_start),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Lock continuation wins only while the burst budget is not exhausted.
    assign w_cont = r_lock_vld && i_req[r_lock_ch] && (r_lock_cnt < CNT_W'(LOCK_MAX));

    // Select the grantee and drive the storage port from it.
    always_comb begin
        w_idx          = w_pick_idx;
        w_any          = w_pick_any;
        o_gnt          = '0;
        o_storage_addr = '0;
        o_storage_data = '0;
        o_storage_we   = 1'b0;
        if (w_cont) begin
            w_idx = r_lock_ch;
            w_any = 1'b1;
        end
        if (w_any) begin
            o_gnt[w_idx]   = 1'b1;
            o_storage_addr = i_addr[32'(w_idx) * ADDR_W +: ADDR_W];
            o_storage_data = i_wdata[32'(w_idx) * DATA_W +: DATA_W];
            o_storage_we   = i_we[w_idx];
        end
    end

    // Arbitration state: rr pointer, lock owner and burst counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_lock_vld <= 1'b0;
            r_lock_ch  <= '0;
            r_lock_cnt <= '0;
        end else if (w_any) begin
            r_lock_vld <= i_lock[w_idx];
            r_lock_ch  <= w_idx;
            if (w_cont) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end else begin
                r_lock_cnt <= '0;
                r_ptr      <= (w_idx == IDX_W'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;
            end
        end else begin
            r_lock_vld <= 1'b0;
            r_lock_cnt <= '0;
        end
    end

    // Read-tag pipeline; its depth matches the storage read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_pipe_id[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_any && !i_we[w_idx];
            r_pipe_id[0]  <= w_idx;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

    // Return read data to the channel tagged at the pipeline output.
    always_comb begin
        o_rvalid = '0;
        o_rdata  = '0;
        if (r_pipe_vld[RD_LAT-1]) begin
            o_rvalid[r_pipe_id[RD_LAT-1]] = 1'b1;
            o_rdata                       = i_storage_rdata;
        end
    end

    assign o_busy = w_any || (|r_pipe_vld);

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench: DUT A is round-robin (RD_LAT=2, LOCK_MAX=4), DUT B is fixed
// priority (RD_LAT=3). Both share the client inputs; each has its own storage model.
module tb_storage_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  we = '0;
    logic [2:0]  lock = '0;
    logic [23:0] addr = '0;
    logic [95:0] wdata = '0;

    logic [2:0]  gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [31:0] rdata_a, rdata_b, sdata_a, sdata_b, srd_a, srd_b;
    logic [7:0]  saddr_a, saddr_b;
    logic        swe_a, swe_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    storage_arbiter #(
        .NUM_CH (3), .ADDR_W (8), .DATA_W (32), .RD_LAT (2), .ARB_MODE (0), .LOCK_MAX (4)
    ) dut_a (
        .clk (clk), .rst (rst), .i_req (req), .i_we (we), .i_lock (lock),
        .i_addr (addr), .i_wdata (wdata), .o_gnt (gnt_a), .o_rvalid (rvalid_a),
        .o_rdata (rdata_a), .o_storage_addr (saddr_a), .o_storage_data (sdata_a),
        .o_storage_we (swe_a), .i_storage_rdata (srd_a), .o_busy (busy_a)
    );

    storage_arbiter #(
        .NUM_CH (3), .ADDR_W (8), .DATA_W (32), .RD_LAT (3), .ARB_MODE (1), .LOCK_MAX (16)
    ) dut_b (
        .clk (clk), .rst (rst), .i_req (req), .i_we (we), .i_lock (lock),
        .i_addr (addr), .i_wdata (wdata), .o_gnt (gnt_b), .o_rvalid (rvalid_b),
        .o_rdata (rdata_b), .o_storage_addr (saddr_b), .o_storage_data (sdata_b),
        .o_storage_we (swe_b), .i_storage_rdata (srd_b), .o_busy (busy_b)
    );

    // Write-first single-port storage models with 2- and 3-cycle read latency.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] rp_a [2];
    logic [31:0] rp_b [3];
    assign srd_a = rp_a[1];
    assign srd_b = rp_b[2];

    always_ff @(posedge clk) begin
        if (swe_a) mem_a[saddr_a] <= sdata_a;
        rp_a[0] <= swe_a ? sdata_a : mem_a[saddr_a];
        rp_a[1] <= rp_a[0];
        if (swe_b) mem_b[saddr_b] <= sdata_b;
        rp_b[0] <= swe_b ? sdata_b : mem_b[saddr_b];
        rp_b[1] <= rp_b[0];
        rp_b[2] <= rp_b[1];
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req  = '0;
            we   = '0;
            lock = '0;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (gnt_a !== 3'b000 || rvalid_a !== 3'b000 || swe_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: gnt=%b rvalid=%b we=%b busy=%b, expected all 0",
                     gnt_a, rvalid_a, swe_a, busy_a);
        end
        checks++;
        if (gnt_b !== 3'b000 || rvalid_b !== 3'b000 || swe_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: gnt=%b rvalid=%b we=%b busy=%b, expected all 0",
                     gnt_b, rvalid_b, swe_b, busy_b);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rr_fairness();
        logic [2:0] exp;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req  = 3'b111;
            we   = 3'b000;
            lock = 3'b000;
            #1;
            exp = 3'b001 << (i % 3);
            checks++;
            if (gnt_a !== exp) begin
                errors++;
                $display("FAIL rr_gnt[%0d]: got %b, expected %b", i, gnt_a, exp);
            end
            checks++;
            if (gnt_b !== 3'b001) begin
                errors++;
                $display("FAIL fixed_all_req[%0d]: got %b, expected 001", i, gnt_b);
            end
        end
        idle(4);
        #1;
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL drain_busy: a=%b b=%b, expected 0 0", busy_a, busy_b);
        end
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        req = 3'b110;
        #1;
        checks++;
        if (gnt_b !== 3'b010) begin
            errors++;
            $display("FAIL fixed_110: got %b, expected 010", gnt_b);
        end
        @(negedge clk);
        req = 3'b111;
        #1;
        checks++;
        if (gnt_b !== 3'b001) begin
            errors++;
            $display("FAIL fixed_111: got %b, expected 001", gnt_b);
        end
        idle(4);
    endtask

    // Write then read of the same address on one channel of DUT A.
    task automatic test_write_read(input int ch, input logic [7:0] a, input logic [31:0] d);
        logic [2:0] oh;
        oh = 3'b001 << ch;
        @(negedge clk);
        req = oh;
        we  = oh;
        addr[ch*8 +: 8]   = a;
        wdata[ch*32 +: 32] = d;
        #1;
        checks++;
        if (gnt_a !== oh || swe_a !== 1'b1 || saddr_a !== a || sdata_a !== d || busy_a !== 1'b1)
        begin
            errors++;
            $display("FAIL wr_cycle ch%0d: gnt=%b we=%b addr=%h data=%h busy=%b, expected %b 1 %h %h 1",
                     ch, gnt_a, swe_a, saddr_a, sdata_a, busy_a, oh, a, d);
        end
        @(negedge clk);
        we = 3'b000;
        #1;
        checks++;
        if (gnt_a !== oh || swe_a !== 1'b0 || rvalid_a !== 3'b000) begin
            errors++;
            $display("FAIL rd_cycle ch%0d: gnt=%b we=%b rvalid=%b, expected %b 0 000",
                     ch, gnt_a, swe_a, rvalid_a, oh);
        end
        @(negedge clk);
        req = 3'b000;
        #1;
        checks++;
        if (rvalid_a !== 3'b000 || swe_a !== 1'b0 || saddr_a !== 8'h00) begin
            errors++;
            $display("FAIL rd_lat1 ch%0d: rvalid=%b we=%b addr=%h, expected 000 0 00",
                     ch, rvalid_a, swe_a, saddr_a);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rvalid_a !== oh || rdata_a !== d) begin
            errors++;
            $display("FAIL rd_lat2 ch%0d: rvalid=%b rdata=%h, expected %b %h",
                     ch, rvalid_a, rdata_a, oh, d);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rvalid_a !== 3'b000 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL rd_after ch%0d: rvalid=%b busy=%b, expected 000 0", ch, rvalid_a, busy_a);
        end
        idle(3);
    endtask

    task automatic test_lock_starvation();
        logic [2:0] exp;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            we   = 3'b000;
            req  = (i == 0) ? 3'b100 : 3'b101;
            lock = (i < 6) ? 3'b100 : 3'b000;
            #1;
            exp = (i == 5) ? 3'b001 : 3'b100;
            checks++;
            if (gnt_a !== exp) begin
                errors++;
                $display("FAIL lock_gnt[%0d]: got %b, expected %b", i, gnt_a, exp);
            end
        end
        idle(4);
    endtask

    // Pointer is 0 after the lock test; ch0/ch2 alternate, rvalid follows 2 cycles later.
    task automatic test_back_to_back();
        logic [2:0] g [6];
        logic [2:0] exp_r;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            we   = 3'b000;
            lock = 3'b000;
            req  = (i < 4) ? 3'b101 : 3'b000;
            #1;
            g[i] = (i < 4) ? ((i % 2 == 0) ? 3'b001 : 3'b100) : 3'b000;
            checks++;
            if (gnt_a !== g[i]) begin
                errors++;
                $display("FAIL b2b_gnt[%0d]: got %b, expected %b", i, gnt_a, g[i]);
            end
            exp_r = (i >= 2) ? g[i-2] : 3'b000;
            checks++;
            if (rvalid_a !== exp_r) begin
                errors++;
                $display("FAIL b2b_rvalid[%0d]: got %b, expected %b", i, rvalid_a, exp_r);
            end
        end
        idle(4);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        req = 3'b001;
        we  = 3'b000;
        #1;
        checks++;
        if (gnt_b !== 3'b001) begin
            errors++;
            $display("FAIL midrst_gnt: got %b, expected 001", gnt_b);
        end
        @(negedge clk);
        req = 3'b000;
        rst = 1'b1;
        #1;
        checks++;
        if (rvalid_b !== 3'b000 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL midrst_during: rvalid=%b busy=%b, expected 000 0", rvalid_b, busy_b);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rvalid_b !== 3'b000 || busy_b !== 1'b0) begin
                errors++;
                $display("FAIL midrst_after[%0d]: rvalid=%b busy=%b, expected 000 0",
                         i, rvalid_b, busy_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_write_read(1, 8'h05, 32'hDEADBEEF);
        test_write_read(0, 8'h10, 32'h12345678);
        test_lock_starvation();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
